// File: rtl/vp_fp16_mul_pipe_pkg.sv
// Purpose: shared binary16 field widths, constants, flag indices and operand classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vp_fp16_mul_pipe_pkg;

  // binary16 field layout and internal datapath widths
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int SIG_W  = MANT_W + 1;   // significand with hidden bit
  localparam int PROD_W = 2 * SIG_W;    // full significand product
  localparam int ESUM_W = 7;            // signed unbiased-ish exponent sum

  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] INF  = 16'h7C00;

  // bit positions inside flags = {invalid, overflow, underflow}
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  // operand-pair class resolved in stage 1, already in priority order
  typedef enum logic [1:0] {
    CLS_NORMAL  = 2'd0,
    CLS_INVALID = 2'd1,
    CLS_INF     = 2'd2,
    CLS_ZERO    = 2'd3
  } cls_e;

endpackage

// File: rtl/vp_fp16_mul_pipe_mask.sv
// Purpose: significand precision mask; clears the rg least-significant significand bits.
// Latency: combinational.
// Backpressure: none (pure function of rg).
module vp_fp16_mul_pipe_mask
  import vp_fp16_mul_pipe_pkg::*;
(
  input  logic [3:0]       rg,
  output logic [SIG_W-1:0] mask_o
);

  // rg=0 keeps full precision; rg>=11 clears the whole significand
  always_comb begin
    mask_o = {SIG_W{1'b1}} << rg;
  end

endmodule

// File: rtl/vp_fp16_mul_pipe.sv
// Purpose: 3-stage binary16 multiplier (unpack/mask, multiply, normalize/pack), truncating, FTZ.
// Latency: result valid in the 3rd cycle after the accepting edge (out_ready held high).
// Backpressure: global stall; every stage holds while out_valid=1 and out_ready=0, in_ready=adv.
module vp_fp16_mul_pipe
  import vp_fp16_mul_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  rg,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  logic adv;

  // ---------------- stage 1: unpack, classify, mask ----------------
  logic [SIG_W-1:0]  mask;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma, mb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_e              cls_in;

  logic              s1_vld_q,  s1_vld_d;
  logic              s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0]  s1_ea_q,   s1_ea_d;
  logic [EXP_W-1:0]  s1_eb_q,   s1_eb_d;
  logic [SIG_W-1:0]  s1_siga_q, s1_siga_d;
  logic [SIG_W-1:0]  s1_sigb_q, s1_sigb_d;
  cls_e              s1_cls_q,  s1_cls_d;

  // ---------------- stage 2: multiply ----------------
  logic                     s2_vld_q,  s2_vld_d;
  logic                     s2_sign_q, s2_sign_d;
  logic signed [ESUM_W-1:0] s2_esum_q, s2_esum_d;
  logic [PROD_W-1:0]        s2_prod_q, s2_prod_d;
  cls_e                     s2_cls_q,  s2_cls_d;

  // ---------------- stage 3: normalize and pack ----------------
  logic [MANT_W-1:0]        mant;
  logic signed [ESUM_W-1:0] e_norm;
  logic                     out_valid_q, out_valid_d;
  logic [15:0]              result_q,    result_d;
  logic [2:0]               flags_q,     flags_d;

  // truncation never looks below p[10]
  logic unused_prod_lsb;
  assign unused_prod_lsb = ^s2_prod_q[9:0];

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  vp_fp16_mul_pipe_mask u_mask (
    .rg     (rg),
    .mask_o (mask)
  );

  // field extraction and operand-pair classification (subnormals count as zero)
  always_comb begin
    ea     = a[14:10];
    eb     = b[14:10];
    ma     = a[9:0];
    mb     = b[9:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_W'(EXP_MAX)) && (ma == '0);
    b_inf  = (eb == EXP_W'(EXP_MAX)) && (mb == '0);
    a_nan  = (ea == EXP_W'(EXP_MAX)) && (ma != '0);
    b_nan  = (eb == EXP_W'(EXP_MAX)) && (mb != '0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      cls_in = CLS_INVALID;
    end else if (a_inf || b_inf) begin
      cls_in = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_in = CLS_ZERO;
    end else begin
      cls_in = CLS_NORMAL;
    end
  end

  // stage 1 next state: capture a new operation on advance, hold otherwise
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_ea_d   = s1_ea_q;
    s1_eb_d   = s1_eb_q;
    s1_siga_d = s1_siga_q;
    s1_sigb_d = s1_sigb_q;
    s1_cls_d  = s1_cls_q;
    if (adv) begin
      s1_vld_d  = in_valid;
      s1_sign_d = a[15] ^ b[15];
      s1_ea_d   = ea;
      s1_eb_d   = eb;
      s1_siga_d = {~a_zero, ma} & mask;
      s1_sigb_d = {~b_zero, mb} & mask;
      s1_cls_d  = cls_in;
    end
  end

  // stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_ea_q   <= '0;
      s1_eb_q   <= '0;
      s1_siga_q <= '0;
      s1_sigb_q <= '0;
      s1_cls_q  <= CLS_NORMAL;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_ea_q   <= s1_ea_d;
      s1_eb_q   <= s1_eb_d;
      s1_siga_q <= s1_siga_d;
      s1_sigb_q <= s1_sigb_d;
      s1_cls_q  <= s1_cls_d;
    end
  end

  // stage 2 next state: significand product and exponent sum minus bias
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_sign_d = s2_sign_q;
    s2_esum_d = s2_esum_q;
    s2_prod_d = s2_prod_q;
    s2_cls_d  = s2_cls_q;
    if (adv) begin
      s2_vld_d  = s1_vld_q;
      s2_sign_d = s1_sign_q;
      s2_esum_d = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q})
                - $signed(ESUM_W'(BIAS));
      s2_prod_d = PROD_W'(s1_siga_q) * PROD_W'(s1_sigb_q);
      s2_cls_d  = s1_cls_q;
    end
  end

  // stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_esum_q <= '0;
      s2_prod_q <= '0;
      s2_cls_q  <= CLS_NORMAL;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_sign_q <= s2_sign_d;
      s2_esum_q <= s2_esum_d;
      s2_prod_q <= s2_prod_d;
      s2_cls_q  <= s2_cls_d;
    end
  end

  // stage 3 next state: normalize by at most one bit, truncate, resolve specials
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s2_prod_q[PROD_W-1]) begin
      mant   = s2_prod_q[20:11];
      e_norm = s2_esum_q + 7'sd1;
    end else begin
      mant   = s2_prod_q[19:10];
      e_norm = s2_esum_q;
    end
    if (adv) begin
      out_valid_d = s2_vld_q;
      if (s2_vld_q) begin
        flags_d = '0;
        case (s2_cls_q)
          CLS_INVALID: begin
            result_d               = QNAN;
            flags_d[FLAG_INVALID]  = 1'b1;
          end
          CLS_INF:  result_d = INF | {s2_sign_q, 15'h0000};
          CLS_ZERO: result_d = {s2_sign_q, 15'h0000};
          default: begin
            if (e_norm >= $signed(ESUM_W'(EXP_MAX))) begin
              result_d               = INF | {s2_sign_q, 15'h0000};
              flags_d[FLAG_OVERFLOW] = 1'b1;
            end else if (e_norm <= 7'sd0) begin
              result_d                = {s2_sign_q, 15'h0000};
              flags_d[FLAG_UNDERFLOW] = 1'b1;
            end else begin
              result_d = {s2_sign_q, e_norm[EXP_W-1:0], mant};
            end
          end
        endcase
      end
    end
  end

  // stage 3 (output) registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      flags_q     <= 3'b000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_vp_fp16_mul_pipe.sv
// Purpose: directed self-checking bench for vp_fp16_mul_pipe.
// Latency: checks out_valid in the 3rd cycle after acceptance.
// Backpressure: exercises a 5-cycle out_ready stall mid-stream and an async reset mid-flight.
module tb_vp_fp16_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic [3:0]  rg;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic [2:0]  flags;

  int n_chk;
  int n_err;

  vp_fp16_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .rg        (rg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one isolated op: accept, check the 3-cycle latency, check result and flags
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic [3:0] vrg, input logic [15:0] exp_res, input logic [2:0] exp_flg);
    @(negedge clk);
    a = va; b = vb; rg = vrg; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; rg = 4'hF;   // later changes must not reach the op in flight
    chk_eq({tag, "_vld_c1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk_eq({tag, "_vld_c2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk_eq({tag, "_vld_c3"}, 32'(out_valid), 32'd1);
    chk_eq({tag, "_res"},    32'(result),    32'(exp_res));
    chk_eq({tag, "_flags"},  32'(flags),     32'(exp_flg));
  endtask

  // stream vectors
  logic [15:0] s_a   [6];
  logic [15:0] s_b   [6];
  logic [3:0]  s_rg  [6];
  logic [15:0] s_exp [6];

  initial begin
    int idx, rx, cyc;
    int first_block;
    logic prev_stall;
    logic [15:0] held;

    n_chk = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; rg = '0;

    // reset state
    #12;
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_result",    32'(result),    32'd0);
    chk_eq("rst_flags",     32'(flags),     32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
    chk_eq("idle_out_valid", 32'(out_valid), 32'd0);

    // directed single operations
    run_op("one_x_one",   16'h3C00, 16'h3C00, 4'd0, 16'h3C00, 3'b000);
    run_op("1p5_sq",      16'h3E00, 16'h3E00, 4'd0, 16'h4080, 3'b000);
    run_op("lsb_rg0",     16'h3C0F, 16'h3C00, 4'd0, 16'h3C0F, 3'b000);
    run_op("lsb_rg4",     16'h3C0F, 16'h3C00, 4'd4, 16'h3C00, 3'b000);
    run_op("two_x_two",   16'h4000, 16'h4000, 4'd0, 16'h4400, 3'b000);
    run_op("ovf",         16'h7BFF, 16'h7BFF, 4'd0, 16'h7C00, 3'b010);
    run_op("unf_pos",     16'h0400, 16'h0400, 4'd0, 16'h0000, 3'b001);
    run_op("unf_neg",     16'h8400, 16'h0400, 4'd0, 16'h8000, 3'b001);
    run_op("inf_x_zero",  16'h7C00, 16'h0000, 4'd0, 16'h7E00, 3'b100);
    run_op("nan_in",      16'h7E00, 16'h3C00, 4'd0, 16'h7E00, 3'b100);
    run_op("ninf_x_one",  16'hFC00, 16'h3C00, 4'd0, 16'hFC00, 3'b000);
    run_op("inf_x_neg2",  16'h7C00, 16'hC000, 4'd0, 16'hFC00, 3'b000);
    run_op("nzero_x_one", 16'h8000, 16'h3C00, 4'd0, 16'h8000, 3'b000);
    run_op("subn_ftz",    16'h0001, 16'h3C00, 4'd0, 16'h0000, 3'b000);
    run_op("inf_x_subn",  16'h7C00, 16'h0001, 4'd0, 16'h7E00, 3'b100);

    // back-to-back stream with a 5-cycle output stall
    s_a[0] = 16'h3C00; s_b[0] = 16'h3C00; s_rg[0] = 4'd0; s_exp[0] = 16'h3C00;
    s_a[1] = 16'h4000; s_b[1] = 16'h4000; s_rg[1] = 4'd0; s_exp[1] = 16'h4400;
    s_a[2] = 16'h3E00; s_b[2] = 16'h3E00; s_rg[2] = 4'd0; s_exp[2] = 16'h4080;
    s_a[3] = 16'hC000; s_b[3] = 16'h4000; s_rg[3] = 4'd0; s_exp[3] = 16'hC400;
    s_a[4] = 16'h3C0F; s_b[4] = 16'h3C00; s_rg[4] = 4'd0; s_exp[4] = 16'h3C0F;
    s_a[5] = 16'h3C0F; s_b[5] = 16'h3C00; s_rg[5] = 4'd4; s_exp[5] = 16'h3C00;
    idx = 0; rx = 0; first_block = -1; prev_stall = 1'b0; held = '0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      if (idx < 6) begin
        in_valid = 1'b1; a = s_a[idx]; b = s_b[idx]; rg = s_rg[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready && first_block < 0) begin
        first_block = cyc;
        chk_eq("stream_held_ops", 32'(idx - rx), 32'd3);
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) chk_eq("stream_stable", 32'(result), 32'(held));
        chk_eq("stream_in_ready_low", 32'(in_ready), 32'd0);
        held = result;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (rx < 6) chk_eq($sformatf("stream_res%0d", rx), 32'(result), 32'(s_exp[rx]));
        else        chk_eq("stream_extra_out", 32'(out_valid), 32'd0);
        rx++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk_eq("stream_accepted", 32'(idx), 32'd6);
    chk_eq("stream_received", 32'(rx), 32'd6);
    chk_eq("stream_block_cycle", 32'(first_block), 32'd5);

    // async reset with 3 ops in flight
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = 16'h4000; b = 16'h4000; rg = 4'd0;
    @(posedge clk); #1;
    a = 16'h3E00; b = 16'h3E00;
    @(posedge clk); #1;
    a = 16'h7BFF; b = 16'h7BFF;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("arst_result",    32'(result),    32'd0);
    chk_eq("arst_flags",     32'(flags),     32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_eq($sformatf("arst_no_stale%0d", k), 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 16'h3E00, 16'h3E00, 4'd0, 16'h4080, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
